// File: rtl/alu_dispatcher_if.sv
// Command push, result pop and sequential-ALU handshake signals of the dispatcher.
// slave is the dispatcher side; master is the environment (producer, consumer and ALU).
interface alu_dispatcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        res_err;

  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [2:0]  alu_op;
  logic        alu_begin;
  logic [15:0] alu_out;
  logic        alu_end;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, res_ready, alu_out, alu_end,
    output cmd_ready, res_valid, res_data, res_op, res_err,
           alu_x, alu_y, alu_op, alu_begin
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, res_ready, alu_out, alu_end,
    input  cmd_ready, res_valid, res_data, res_op, res_err,
           alu_x, alu_y, alu_op, alu_begin
  );
endinterface

// File: rtl/alu_dispatcher.sv
// Queues ALU commands and runs them one at a time on an external sequential ALU,
// holding each result (or a timeout error) until the consumer pops it.
module alu_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            resetn,
  alu_dispatcher_if.slave bus,
  output logic            busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [18:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             fifo_empty, fifo_full, push, pop;
  logic [18:0]      head;

  state_t      state_reg, state_next;
  logic [7:0]  x_reg, x_next, y_reg, y_next;
  logic [2:0]  op_reg, op_next;
  logic        res_valid_reg, res_valid_next;
  logic [15:0] res_data_reg, res_data_next;
  logic [2:0]  res_op_reg, res_op_next;
  logic        res_err_reg, res_err_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        arm_reg, arm_next;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign push       = bus.cmd_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr_reg];

  // Entry layout: {op, x, y}. Storage needs no reset; count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_op, bus.cmd_x, bus.cmd_y};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    op_next        = op_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    res_op_next    = res_op_reg;
    res_err_next   = res_err_reg;
    wait_cnt_next  = wait_cnt_reg;
    arm_next       = arm_reg;
    pop            = 1'b0;

    if (res_valid_reg && bus.res_ready) res_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !res_valid_reg) begin
          pop                       = 1'b1;
          {op_next, x_next, y_next} = head;
          res_op_next               = head[18:16];
          state_next                = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_next = '0;
        arm_next      = 1'b0;
        state_next    = WAIT;
      end
      WAIT: begin
        // An END already high when the wait began must drop once before it counts.
        if (arm_reg && bus.alu_end) begin
          res_data_next  = bus.alu_out;
          res_err_next   = 1'b0;
          res_valid_next = 1'b1;
          state_next     = IDLE;
        end else if (wait_cnt_reg == TIMEOUT_CNT) begin
          res_data_next  = 16'h0000;
          res_err_next   = 1'b1;
          res_valid_next = 1'b1;
          state_next     = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (!bus.alu_end) arm_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      op_reg        <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_op_reg    <= '0;
      res_err_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
      arm_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      op_reg        <= op_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_op_reg    <= res_op_next;
      res_err_reg   <= res_err_next;
      wait_cnt_reg  <= wait_cnt_next;
      arm_reg       <= arm_next;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_begin = (state_reg == ISSUE);
  assign bus.alu_x     = x_reg;
  assign bus.alu_y     = y_reg;
  assign bus.alu_op    = op_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_op    = res_op_reg;
  assign bus.res_err   = res_err_reg;
  assign busy          = (state_reg != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_dispatcher.sv
// Self-checking bench: transaction-level model of queue, issue timing, END arming and
// timeout, checked against the dispatcher every cycle, plus directed literal cases.
module tb_alu_dispatcher;
  localparam int DEPTH = 4;
  localparam int TOUT  = 20;

  logic clk;
  logic resetn;
  logic busy;

  alu_dispatcher_if bus ();

  alu_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind 0: END pulse at WAIT cycle d; kind 1: END high for WAIT cycles 1..d,
  // low for two, then high; kind 2: END never rises.
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] out;
    int          kind;
    int          d;
    int          push_cycle;
  } cmd_t;

  int compared   = 0;
  int mismatched = 0;

  cmd_t        q[$];
  cmd_t        cur;
  int          cycle = 0;
  bit          in_flight = 0;
  bit          rv_model = 0;
  bit          prev_ready = 0;
  int          begin_cycle = 0;
  int          exp_done = 0;
  logic [15:0] exp_data, last_data;
  logic        exp_err, last_err;
  logic [2:0]  last_op;
  int          last_latency = 0;
  int          n_results = 0;
  bit          push_ack = 0;
  bit          idle_end = 0;
  int          drv_kind = 0;
  int          drv_d = 0;
  logic [15:0] drv_out = '0;
  logic [15:0] pop_data;
  logic [2:0]  pop_op;
  logic        pop_err;
  int          rj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic logic [15:0] alu_func(input logic [2:0] op, input logic [7:0] x,
                                           input logic [7:0] y);
    case (op)
      3'd0:    return {8'h00, x & y};
      3'd1:    return {8'h00, x | y};
      3'd2:    return {8'h00, x ^ y};
      3'd3:    return 16'(x) + 16'(y);
      3'd4:    return 16'(x) - 16'(y);
      3'd5:    return 16'(x) * 16'(y);
      3'd6:    return {x, y};
      default: return {y, x};
    endcase
  endfunction

  function automatic bit level_at(input cmd_t c, input int j);
    case (c.kind)
      0:       return (j == c.d);
      1:       return (j <= c.d) || (j >= c.d + 3);
      default: return 1'b0;
    endcase
  endfunction

  // WAIT cycle j sees wait counter j-1; timeout lands in WAIT cycle TOUT+1.
  function automatic void predict(input cmd_t c, output int j, output logic [15:0] data,
                                  output logic err);
    bit armed = 0;
    j = TOUT + 1; data = 16'h0000; err = 1'b1;
    for (int k = 1; k <= TOUT + 1; k++) begin
      bit lvl = level_at(c, k);
      if (armed && lvl) begin
        j = k; data = c.out; err = 1'b0;
        return;
      end
      if (k == TOUT + 1) begin
        j = k; data = 16'h0000; err = 1'b1;
        return;
      end
      if (!lvl) armed = 1;
    end
  endfunction

  // Compare process
  always @(negedge clk) begin
    cycle++;
    if (!resetn) begin
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_res_data", 32'(bus.res_data), 0);
      chk("rst_res_op", 32'(bus.res_op), 0);
      chk("rst_res_err", 32'(bus.res_err), 0);
      chk("rst_alu_begin", 32'(bus.alu_begin), 0);
      chk("rst_alu_xyop", {13'd0, bus.alu_op, bus.alu_x, bus.alu_y}, 0);
      chk("rst_busy", 32'(busy), 0);
      q.delete();
      in_flight  = 0;
      rv_model   = 0;
      prev_ready = 0;
      last_data  = '0;
      last_err   = 1'b0;
      last_op    = '0;
    end else begin
      chk("alu_begin", 32'(bus.alu_begin), 32'(prev_ready));
      if (prev_ready) begin
        int          j;
        logic [15:0] d;
        logic        e;
        cur = q.pop_front();
        in_flight    = 1;
        begin_cycle  = cycle;
        last_latency = cycle - cur.push_cycle;
        predict(cur, j, d, e);
        exp_done = cycle + j + 1;
        exp_data = d;
        exp_err  = e;
        last_op  = cur.op;
      end
      if (in_flight && cycle == exp_done) begin
        in_flight = 0;
        rv_model  = 1;
        last_data = exp_data;
        last_err  = exp_err;
      end
      chk("res_valid", 32'(bus.res_valid), 32'(rv_model));
      chk("res_data", 32'(bus.res_data), 32'(last_data));
      chk("res_err", 32'(bus.res_err), 32'(last_err));
      chk("res_op", 32'(bus.res_op), 32'(last_op));
      if (in_flight) chk("alu_operands", {13'd0, bus.alu_op, bus.alu_x, bus.alu_y},
                         {13'd0, cur.op, cur.x, cur.y});
      chk("busy", 32'(busy), 32'(q.size() > 0 || in_flight));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() < DEPTH));
      prev_ready = !in_flight && q.size() > 0 && !rv_model;
      if (rv_model && bus.res_ready) begin
        rv_model = 0;
        n_results++;
        pop_data = bus.res_data;
        pop_op   = bus.res_op;
        pop_err  = bus.res_err;
        $display("txn %0d: op=%0d data=%h err=%0d cycle=%0d", n_results, pop_op, pop_data,
                 pop_err, cycle);
      end
      if (bus.cmd_valid && q.size() < DEPTH) begin
        cmd_t c;
        c.op = bus.cmd_op; c.x = bus.cmd_x; c.y = bus.cmd_y;
        c.out = drv_out; c.kind = drv_kind; c.d = drv_d; c.push_cycle = cycle;
        q.push_back(c);
        push_ack = 1;
      end
    end
  end

  // Sequential ALU model: drives END and the result according to the issued command's plan.
  initial begin
    bus.alu_end = 1'b0;
    bus.alu_out = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (in_flight) begin
        rj = cycle + 1 - begin_cycle;
        bus.alu_end = level_at(cur, rj);
        bus.alu_out = (cur.kind == 1 && rj <= cur.d) ? 16'hDEAD : cur.out;
      end else begin
        bus.alu_end = idle_end;
      end
    end
  end

  task automatic set_cmd(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         input int kind, input int d, input logic [15:0] out);
    bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
    drv_kind = kind; drv_d = d; drv_out = out;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                          input int kind, input int d, input logic [15:0] out);
    set_cmd(op, x, y, kind, d, out);
    push_ack = 0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !push_ack; i++) begin
      @(posedge clk);
      #1;
    end
    if (!push_ack) chk("push_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
    push_ack = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!busy && !bus.res_valid) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    resetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Single operation, END ten cycles after issue
    bus.res_ready = 1'b1;
    push_cmd(3'd0, 8'h0C, 8'h0A, 0, 10, alu_func(3'd0, 8'h0C, 8'h0A));
    wait_idle();
    chk("single_latency", 32'(last_latency), 2);
    chk("single_data", 32'(pop_data), 32'h0008);
    chk("single_op", 32'(pop_op), 0);
    chk("single_err", 32'(pop_err), 0);

    // Backpressure: 1 in flight + 4 queued, the 6th push held off
    @(posedge clk); #1 bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] op = 3'(i + 1);
      logic [7:0] x = 8'(8'h10 + i);
      push_cmd(op, x, 8'h03, 0, 3, alu_func(op, x, 8'h03));
    end
    set_cmd(3'd7, 8'hA5, 8'h5A, 0, 3, alu_func(3'd7, 8'hA5, 8'h5A));
    push_ack = 0;
    bus.cmd_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("full_holdoff", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    for (int i = 0; i < 100 && !push_ack; i++) begin
      @(posedge clk);
      #1;
    end
    if (!push_ack) chk("sixth_push_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
    push_ack = 0;
    wait_idle();
    chk("order_last_op", 32'(pop_op), 7);

    // Stale END held across ISSUE
    idle_end = 1;
    push_cmd(3'd2, 8'h33, 8'h44, 1, 3, 16'h1234);
    for (int i = 0; i < 20 && !in_flight; i++) @(negedge clk);
    @(posedge clk); #1 idle_end = 0;
    wait_idle();
    chk("stale_data", 32'(pop_data), 32'h1234);
    chk("stale_err", 32'(pop_err), 0);

    // Timeout, followed by a queued command issued after the pop
    bus.res_ready = 1'b0;
    push_cmd(3'd1, 8'h01, 8'h02, 2, 0, 16'hBEEF);
    push_cmd(3'd3, 8'h05, 8'h06, 0, 5, alu_func(3'd3, 8'h05, 8'h06));
    for (int i = 0; i < 100 && !bus.res_valid; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("timeout_err", 32'(bus.res_err), 1);
    chk("timeout_data", 32'(bus.res_data), 0);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    wait_idle();
    chk("after_timeout_data", 32'(pop_data), 32'h000B);

    // END in exactly the timeout cycle wins; one cycle later loses; earliest armed END
    push_cmd(3'd3, 8'h40, 8'h02, 0, TOUT + 1, alu_func(3'd3, 8'h40, 8'h02));
    wait_idle();
    chk("collision_err", 32'(pop_err), 0);
    chk("collision_data", 32'(pop_data), 32'h0042);
    push_cmd(3'd3, 8'h40, 8'h02, 0, TOUT + 2, alu_func(3'd3, 8'h40, 8'h02));
    wait_idle();
    chk("late_end_err", 32'(pop_err), 1);
    push_cmd(3'd5, 8'h10, 8'h10, 0, 2, alu_func(3'd5, 8'h10, 8'h10));
    wait_idle();
    chk("early_end_data", 32'(pop_data), 32'h0100);

    // Reset mid-WAIT with three queued, then a stray END
    push_cmd(3'd4, 8'h09, 8'h01, 2, 0, 16'h0);
    for (int i = 0; i < 3; i++) push_cmd(3'd1, 8'(i), 8'h80, 0, 4, alu_func(3'd1, 8'(i), 8'h80));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1 idle_end = 1;
    @(posedge clk); #1 idle_end = 0;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_valid", 32'(bus.res_valid), 0);
    chk("post_reset_ready", 32'(bus.cmd_ready), 1);

    // Randomized traffic
    begin
      int n_sent = 0;
      for (int c = 0; c < 4000 && n_sent < 60; c++) begin
        @(posedge clk);
        #1;
        bus.res_ready = ($urandom_range(0, 3) != 0);
        if (bus.cmd_valid && push_ack) begin
          push_ack = 0;
          bus.cmd_valid = 1'b0;
          n_sent++;
        end
        if (!bus.cmd_valid && n_sent < 60 && $urandom_range(0, 1) == 1) begin
          int          r = int'($urandom_range(0, 9));
          int          kind = (r == 0) ? 2 : (r < 3) ? 1 : 0;
          int          d = (kind == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(2, 23));
          logic [2:0]  op = 3'($urandom_range(0, 7));
          logic [7:0]  x = 8'($urandom_range(0, 255));
          logic [7:0]  y = 8'($urandom_range(0, 255));
          set_cmd(op, x, y, kind, d, alu_func(op, x, y));
          push_ack = 0;
          bus.cmd_valid = 1'b1;
        end
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      wait_idle();
      chk("random_all_sent", 32'(n_sent), 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
